// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
package i2c_pkg;

    // Transaction phases, visited in this order (ACK1 may skip to STOP on NACK).
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StAck1,
        StWdata,
        StRdata,
        StAck2,
        StStop
    } i2c_state_e;

    // Quarter of a bit period: Q0/Q1 SCL low, Q2/Q3 SCL high.
    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // SCL level during a normal data/ack bit.
    function automatic logic scl_high(input quarter_e q);
        return (q == Q2) || (q == Q3);
    endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-bit tick divider: one-cycle tick every CLK_DIV clk cycles while en is high.
module i2c_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [9:0] CntLast = 10'(CLK_DIV - 1);

    logic [9:0] cnt_q, cnt_d;

    // Count while enabled; hold at zero while idle so the first tick is a full period away.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == CntLast) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 10'd1;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CntLast);

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Optional macro I2C_MASTER_ACK_CHECK_EN: honour target NACKs and report them on ack_err.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_out,
    inout  wire        sda_out
);

    i2c_state_e state_q, state_d;
    quarter_e   phase_q, phase_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] addr_byte_q, addr_byte_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       done_q, done_d;
    logic       tick, sda_oe, sda_in, rw_q;
`ifdef I2C_MASTER_ACK_CHECK_EN
    logic       ack_bit_q, ack_bit_d;
    logic       ack_err_q, ack_err_d;
`endif

    assign busy    = (state_q != StIdle);
    assign rw_q    = addr_byte_q[0];
    assign sda_out = sda_oe ? 1'b0 : 1'bz;
    assign sda_in  = sda_out;
    assign rdata   = rdata_q;
    assign done    = done_q;
`ifdef I2C_MASTER_ACK_CHECK_EN
    assign ack_err = ack_err_q;
`else
    assign ack_err = 1'b0;
`endif

    i2c_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (busy),
        .tick (tick)
    );

    // Next state: accept start in idle, otherwise step one quarter per tick.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        addr_byte_d = addr_byte_q;
        wdata_d     = wdata_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
        ack_bit_d   = ack_bit_q;
        ack_err_d   = ack_err_q;
`endif
        if (state_q == StIdle) begin
            if (start) begin
                state_d     = StStart;
                phase_d     = Q0;
                addr_byte_d = {addr, rw};
                wdata_d     = wdata;
`ifdef I2C_MASTER_ACK_CHECK_EN
                ack_err_d   = 1'b0;
`endif
            end
        end else if (tick) begin
            phase_d = quarter_e'(phase_q + 2'd1);
            // Sample at the end of Q2 so the target has had the whole SCL-low half to settle.
            if (phase_q == Q2) begin
                if (state_q == StRdata) rx_d = {rx_q[6:0], sda_in};
`ifdef I2C_MASTER_ACK_CHECK_EN
                if (state_q == StAck1 || state_q == StAck2) ack_bit_d = sda_in;
`endif
            end
            if (phase_q == Q3) begin
                unique case (state_q)
                    StIdle:  state_d = StIdle;
                    StStart: begin
                        state_d   = StAddr;
                        bit_cnt_d = 3'd7;
                    end
                    StAddr: begin
                        if (bit_cnt_q == 3'd0) state_d = StAck1;
                        else bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                    StAck1: begin
                        state_d   = rw_q ? StRdata : StWdata;
                        bit_cnt_d = 3'd7;
`ifdef I2C_MASTER_ACK_CHECK_EN
                        if (ack_bit_q == I2C_NACK) begin
                            state_d   = StStop;
                            ack_err_d = 1'b1;
                        end
`endif
                    end
                    StWdata, StRdata: begin
                        if (bit_cnt_q == 3'd0) state_d = StAck2;
                        else bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                    StAck2: begin
                        state_d = StStop;
                        if (rw_q) rdata_d = rx_q;
`ifdef I2C_MASTER_ACK_CHECK_EN
                        if (!rw_q && ack_bit_q == I2C_NACK) ack_err_d = 1'b1;
`endif
                    end
                    StStop: begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    // Bus levels decoded from state and quarter; SDA is only ever pulled low.
    always_comb begin
        scl_out = 1'b1;
        sda_oe  = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StStart: sda_oe = scl_high(phase_q);
            StAddr: begin
                scl_out = scl_high(phase_q);
                sda_oe  = !addr_byte_q[bit_cnt_q];
            end
            StWdata: begin
                scl_out = scl_high(phase_q);
                sda_oe  = !wdata_q[bit_cnt_q];
            end
            // ACK2 on a read releases SDA, which is the master NACK.
            StAck1, StAck2, StRdata: scl_out = scl_high(phase_q);
            StStop: begin
                scl_out = (phase_q != Q0);
                sda_oe  = (phase_q == Q0) || (phase_q == Q1);
            end
        endcase
    end

    // State registers; reset drops the bus immediately without a STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            phase_q     <= Q0;
            bit_cnt_q   <= 3'd7;
            addr_byte_q <= '0;
            wdata_q     <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
            ack_bit_q   <= I2C_ACK;
            ack_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_byte_q <= addr_byte_d;
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
`ifdef I2C_MASTER_ACK_CHECK_EN
            ack_bit_q   <= ack_bit_d;
            ack_err_q   <= ack_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: target model on the CLK_DIV=4 bus, timing on CLK_DIV=1/10.
module tb_i2c_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start1, start10, rw;
    logic [6:0] addr;
    logic [7:0] wdata;

    wire        sda0, sda1, sda10;
    pullup pu0 (sda0);
    pullup pu1 (sda1);
    pullup pu10 (sda10);

    logic [7:0] rdata0, rdata1, rdata10;
    logic       busy0, busy1, busy10, done0, done1, done10;
    logic       ack_err0, ack_err1, ack_err10, scl0, scl1, scl10;

    // Target model state
    logic       tgt_low = 1'b0;
    logic       tgt_present = 1'b0;
    logic [7:0] tgt_byte = 8'h00;
    assign sda0 = tgt_low ? 1'b0 : 1'bz;

    int n_checks = 0;
    int n_fail = 0;

    i2c_master #(.CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(rdata0), .busy(busy0), .done(done0), .ack_err(ack_err0),
        .scl_out(scl0), .sda_out(sda0)
    );

    i2c_master #(.CLK_DIV(1)) dut_div1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(rdata1), .busy(busy1), .done(done1), .ack_err(ack_err1),
        .scl_out(scl1), .sda_out(sda1)
    );

    i2c_master #(.CLK_DIV(10)) dut_div10 (
        .clk(clk), .rst_n(rst_n), .start(start10), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(rdata10), .busy(busy10), .done(done10), .ack_err(ack_err10),
        .scl_out(scl10), .sda_out(sda10)
    );

    // Bus monitor and target for the CLK_DIV=4 instance, sampled on the falling clk edge.
    int   nrise = 0;
    int   n_start = 0;
    int   n_stop = 0;
    int   n_done = 0;
    logic bitv [0:31];
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            tgt_low = 1'b0;
        end else begin
            if (prev_scl && scl0 && prev_sda && !sda0) begin
                n_start++;
                nrise = 0;
            end
            if (prev_scl && scl0 && !prev_sda && sda0) n_stop++;
            if (!prev_scl && scl0) begin
                if (nrise < 32) bitv[nrise] = sda0;
                nrise++;
            end
            if (done0) n_done++;
            // On SCL fall, set the target's drive for the coming bit slot.
            if (prev_scl && !scl0) begin
                tgt_low = 1'b0;
                if (tgt_present) begin
                    if (nrise == 8) tgt_low = 1'b1;
                    else if (nrise >= 9 && nrise <= 16 && bitv[7]) tgt_low = !tgt_byte[16 - nrise];
                    else if (nrise == 17 && !bitv[7]) tgt_low = 1'b1;
                end
            end
        end
        prev_scl = scl0;
        prev_sda = sda0;
    end

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7 - i] = bitv[base + i];
        return b;
    endfunction

    // Launch one transaction on the CLK_DIV=4 instance and wait (bounded) for done.
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                           input int repulse_at, output int cyc, output logic busy_mid,
                           output int nd, output int ns, output int np);
        int s_done, s_start, s_stop;
        s_done = n_done; s_start = n_start; s_stop = n_stop;
        busy_mid = 1'b0;
        @(negedge clk);
        addr = a; rw = r; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == repulse_at);
            if (cyc == repulse_at) addr = 7'h11;
            if (cyc == 8) busy_mid = busy0;
        end
        start = 1'b0;
        n_checks++;
        if (done0 !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done0, cyc);
        end
        repeat (4) @(negedge clk);
        nd = n_done - s_done; ns = n_start - s_start; np = n_stop - s_stop;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; start10 = 1'b0;
        addr = '0; rw = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (scl0 !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b want 1", scl0); end
        if (sda0 !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda0); end
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
        if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
        if (ack_err0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0", ack_err0); end
        if (rdata0 !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata0); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write;
        int cyc, nd, ns, np;
        logic bm;
        tgt_present = 1'b1;
        run_txn(7'h50, 1'b0, 8'hA5, 0, cyc, bm, nd, ns, np);
        n_checks += 9;
        if (get_byte(0) !== 8'hA0) begin n_fail++; $display("FAIL wr_addr_byte: got %h want a0", get_byte(0)); end
        if (get_byte(9) !== 8'hA5) begin n_fail++; $display("FAIL wr_data_byte: got %h want a5", get_byte(9)); end
        if (ack_err0 !== 1'b0) begin n_fail++; $display("FAIL wr_ack_err: got %b want 0", ack_err0); end
        if (nd != 1) begin n_fail++; $display("FAIL wr_done_count: got %0d want 1", nd); end
        if (ns != 1 || np != 1) begin n_fail++; $display("FAIL wr_start_stop: got %0d/%0d want 1/1", ns, np); end
        if (cyc < 320 || cyc > 322) begin n_fail++; $display("FAIL wr_latency: got %0d want 320..322", cyc); end
        if (nrise != 19) begin n_fail++; $display("FAIL wr_scl_pulses: got %0d want 19", nrise); end
        if (bm !== 1'b1) begin n_fail++; $display("FAIL wr_busy_mid: got %b want 1", bm); end
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL wr_busy_end: got %b want 0", busy0); end
    endtask

    task automatic test_read;
        int cyc, nd, ns, np;
        logic bm;
        tgt_present = 1'b1; tgt_byte = 8'h3C;
        run_txn(7'h50, 1'b1, 8'h00, 0, cyc, bm, nd, ns, np);
        n_checks += 5;
        if (rdata0 !== 8'h3C) begin n_fail++; $display("FAIL rd_rdata: got %h want 3c", rdata0); end
        if (get_byte(0) !== 8'hA1) begin n_fail++; $display("FAIL rd_addr_byte: got %h want a1", get_byte(0)); end
        if (bitv[17] !== 1'b1) begin n_fail++; $display("FAIL rd_master_nack: got %b want 1", bitv[17]); end
        if (nd != 1) begin n_fail++; $display("FAIL rd_done_count: got %0d want 1", nd); end
        if (cyc < 320 || cyc > 322) begin n_fail++; $display("FAIL rd_latency: got %0d want 320..322", cyc); end
    endtask

    task automatic test_nack;
        int cyc, nd, ns, np;
        logic bm;
        tgt_present = 1'b0;
        run_txn(7'h50, 1'b0, 8'hA5, 0, cyc, bm, nd, ns, np);
        n_checks += 5;
        if (bitv[8] !== 1'b1) begin n_fail++; $display("FAIL nk_ack1_level: got %b want 1", bitv[8]); end
        if (nd != 1) begin n_fail++; $display("FAIL nk_done_count: got %0d want 1", nd); end
`ifdef I2C_MASTER_ACK_CHECK_EN
        if (ack_err0 !== 1'b1) begin n_fail++; $display("FAIL nk_ack_err: got %b want 1", ack_err0); end
        if (cyc < 176 || cyc > 178) begin n_fail++; $display("FAIL nk_latency: got %0d want 176..178", cyc); end
        if (nrise != 10) begin n_fail++; $display("FAIL nk_scl_pulses: got %0d want 10", nrise); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (ack_err0 !== 1'b1) begin n_fail++; $display("FAIL nk_ack_err_hold: got %b want 1", ack_err0); end
`else
        if (ack_err0 !== 1'b0) begin n_fail++; $display("FAIL nk_ack_err: got %b want 0", ack_err0); end
        if (cyc < 320 || cyc > 322) begin n_fail++; $display("FAIL nk_latency: got %0d want 320..322", cyc); end
        if (nrise != 19) begin n_fail++; $display("FAIL nk_scl_pulses: got %0d want 19", nrise); end
`endif
    endtask

    task automatic test_back_to_back;
        int cyc, nd, ns, np, s_done;
        logic bm;
        tgt_present = 1'b1;
        run_txn(7'h50, 1'b0, 8'hA5, 100, cyc, bm, nd, ns, np);
        n_checks += 5;
        if (nd != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", nd); end
        if (get_byte(0) !== 8'hA0) begin n_fail++; $display("FAIL b2b_addr_byte: got %h want a0", get_byte(0)); end
        if (cyc < 320 || cyc > 322) begin n_fail++; $display("FAIL b2b_latency: got %0d want 320..322", cyc); end
        if (ack_err0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_err: got %b want 0", ack_err0); end
        s_done = n_done;
        repeat (40) @(negedge clk);
        if (busy0 !== 1'b0 || n_done != s_done) begin
            n_fail++;
            $display("FAIL b2b_no_second: busy=%b extra_done=%0d want 0/0", busy0, n_done - s_done);
        end
    endtask

    task automatic test_reset_mid;
        int c, s_start, s_stop, cyc, nd, ns, np;
        logic bm;
        tgt_present = 1'b1;
        s_start = n_start;
        @(negedge clk);
        addr = 7'h50; rw = 1'b0; wdata = 8'hA5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while ((n_start == s_start || nrise < 12 || scl0) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        n_checks += 6;
        if (scl0 !== 1'b0 || sda0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_pre_state: scl=%b sda=%b want 0/0", scl0, sda0);
        end
        s_stop = n_stop;
        #1 rst_n = 1'b0;
        #1;
        if (scl0 !== 1'b1) begin n_fail++; $display("FAIL rm_async_scl: got %b want 1", scl0); end
        if (sda0 !== 1'b1) begin n_fail++; $display("FAIL rm_async_sda: got %b want 1", sda0); end
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rm_async_busy: got %b want 0", busy0); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        if (n_stop != s_stop) begin n_fail++; $display("FAIL rm_no_stop: got %0d stops want 0", n_stop - s_stop); end
        if (done0 !== 1'b0) begin n_fail++; $display("FAIL rm_done: got %b want 0", done0); end
        run_txn(7'h50, 1'b0, 8'hA5, 0, cyc, bm, nd, ns, np);
        n_checks += 3;
        if (get_byte(9) !== 8'hA5) begin n_fail++; $display("FAIL rm_data_byte: got %h want a5", get_byte(9)); end
        if (nd != 1) begin n_fail++; $display("FAIL rm_done_count: got %0d want 1", nd); end
        if (cyc < 320 || cyc > 322) begin n_fail++; $display("FAIL rm_latency: got %0d want 320..322", cyc); end
    endtask

    task automatic test_clk_div;
        int r1, r10, t1a, t1b, t10a, t10b, hc1, hc10, d1, d10;
        logic ps1, pd1, ps10, pd10;
        r1 = 0; r10 = 0; t1a = 0; t1b = 0; t10a = 0; t10b = 0;
        hc1 = 0; hc10 = 0; d1 = 0; d10 = 0;
        @(negedge clk);
        addr = 7'h50; rw = 1'b0; wdata = 8'hA5; start1 = 1'b1; start10 = 1'b1;
        ps1 = scl1; pd1 = sda1; ps10 = scl10; pd10 = sda10;
        @(negedge clk);
        start1 = 1'b0; start10 = 1'b0;
        for (int c = 0; c < 3400; c++) begin
            if (!ps1 && scl1) begin
                if (r1 == 0) t1a = c;
                if (r1 == 1) t1b = c;
                r1++;
            end
            if (!ps10 && scl10) begin
                if (r10 == 0) t10a = c;
                if (r10 == 1) t10b = c;
                r10++;
            end
            if (ps1 && scl1 && pd1 !== sda1) hc1++;
            if (ps10 && scl10 && pd10 !== sda10) hc10++;
            if (done1) d1++;
            if (done10) d10++;
            ps1 = scl1; pd1 = sda1; ps10 = scl10; pd10 = sda10;
            @(negedge clk);
        end
        n_checks += 6;
        if (t1b - t1a != 4) begin n_fail++; $display("FAIL div1_scl_period: got %0d want 4", t1b - t1a); end
        if (t10b - t10a != 40) begin n_fail++; $display("FAIL div10_scl_period: got %0d want 40", t10b - t10a); end
        if (hc1 != 2) begin n_fail++; $display("FAIL div1_sda_while_scl_high: got %0d want 2", hc1); end
        if (hc10 != 2) begin n_fail++; $display("FAIL div10_sda_while_scl_high: got %0d want 2", hc10); end
        if (d1 != 1) begin n_fail++; $display("FAIL div1_done_count: got %0d want 1", d1); end
        if (d10 != 1) begin n_fail++; $display("FAIL div10_done_count: got %0d want 1", d10); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_back_to_back();
        test_reset_mid();
        test_clk_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
